ibf_pipe: RTL and testbench
===========================

Name: ibf_pipe

Overview:
- Pipelined inverse radix-2 butterfly: the receive/decode direction of the forward add/sub butterfly.
- Recovers the original operand pair from a sum/difference pair: a = (s+d)/2, b = (s-d)/2.
- Sits on the IFFT/verification path of the 16-point FFT datapath.
- Streams via valid/ready, checks parity consistency and range, counts errors.

Parameters:
IL, 17, input word width (two's complement; forward butterfly output width)
OL, IL-1, output word width (recovered operand width)
CW, 8, error counter width

Ports:
iCLK  input  1  clock, rising edge
iRST  input  1  asynchronous active-high reset
iDATA_add  input  IL  sum word s (signed)
iDATA_sub  input  IL  difference word d (signed)
iVALID  input  1  input beat valid
iREADY  output  1  block can accept input beat
oDATA1  output  OL  recovered a (signed)
oDATA2  output  OL  recovered b (signed)
oVALID  output  1  output beat valid
oREADY  input  1  downstream accepts output beat
oPAR_ERR  output  1  1-cycle pulse when an output beat with odd s+d is accepted downstream
oRNG_ERR  output  1  1-cycle pulse when an output beat with out-of-range result is accepted downstream
oERR_CNT  output  CW  count of erroneous beats, saturating at all-ones
iCLR_ERR  input  1  synchronous clear of oERR_CNT

Behaviour:
- One clock (iCLK); reset is asynchronous and active-high (iRST).
- Reset values: all stage valids 0, oVALID 0, oDATA1/oDATA2 0, oPAR_ERR/oRNG_ERR 0, oERR_CNT 0.
- Transfers:
  - Input transfer when iVALID && iREADY.
  - Output transfer when oVALID && oREADY.
- Stage 1 (S1) registers:
  - sum = sext(s)+sext(d) and dif = sext(s)-sext(d), both IL+1 bits, exact, no overflow.
  - par = s[0]^d[0].
- Stage 2 (S2) registers:
  - r1 = sum>>>1, r2 = dif>>>1 (arithmetic shift, floor), IL bits.
  - Range check: rng = r1 or r2 not representable in OL bits.
  - Reduce to OL bits per the IBF_SAT_EN rule.
  - Carry par and rng into S2 alongside the data.
- Latency: 2 cycles from input transfer to oVALID when unstalled. Throughput 1 beat/cycle.
- Stall and ready:
  - s2_adv = !oVALID || oREADY.
  - s1_adv = !s1_valid || s2_adv.
  - iREADY = s1_adv (combinational from oREADY; no skid buffer).
  - A stalled stage holds data and valid unchanged.
  - oDATA1/oDATA2 are stable while oVALID && !oREADY.
- Errors:
  - oPAR_ERR and oRNG_ERR pulse for exactly one cycle, the cycle after the output transfer, only for the flagged beat.
  - A beat with both errors asserts both pulses but increments oERR_CNT by 1.
  - oERR_CNT saturates at 2^CW-1.
  - iCLR_ERR has priority over a same-cycle increment: result is 0.
- Reset mid-operation: in-flight beats are discarded with no output transfer; iREADY=1 in the first cycle after release.
- oDATA1/oDATA2 when oVALID=0: hold last value (don't-care for the bench).

Optional Feature:
IBF_SAT_EN
- Defined: out-of-range r1/r2 clamp to +2^(OL-1)-1 or -2^(OL-1).
- Undefined: results wrap (keep low OL bits).
- oRNG_ERR and the error count behave the same in both builds.

Decomposition:
- Package ibf_pkg:
  - Default widths IL/OL/CW.
  - Saturation limit constants MAX_OL / MIN_OL.
  - Function sat_or_wrap(IL-bit) -> OL-bit, honouring IBF_SAT_EN.
- One sub-module, ibf_reduce (combinational): shift, range check, saturate/wrap. Instantiated twice in S2.
- Handshake and counter live in the top level.

Test Plan:
- Round trip: s=70, d=130 (from a=100, b=-30), oREADY=1 -> 2 cycles later oDATA1=100, oDATA2=-30, no errors.
- Backpressure: stream 4 valid beats with oREADY=0 for 3 cycles -> iREADY low after 2 accepted, outputs held stable, all 4 beats emerge in order, none lost or duplicated.
- Parity error: s=3, d=0 -> oDATA1=1, oDATA2=1, oPAR_ERR pulse, oERR_CNT=1.
- Range error: s=65535, d=65535 -> r1=65535, r2=0; with IBF_SAT_EN oDATA1=32767, without it oDATA1=-1; oDATA2=0, oRNG_ERR pulse.
- Counter: 300 parity-error beats -> oERR_CNT=255. Then iCLR_ERR concurrent with an error beat -> 0.
- Reset: assert iRST while 2 beats are in flight -> oVALID=0 asynchronously, oERR_CNT=0, no output transfer after release.

Source files
------------

// File: rtl/ibf_pkg.sv
// ibf_pkg: widths, clamp limits and the saturate-or-wrap reduction; IBF_SAT_EN selects clamping.
package ibf_pkg;
  localparam int IL = 17;
  localparam int OL = IL - 1;
  localparam int CW = 8;
  localparam logic [OL-1:0] MAX_OL = {1'b0, {(OL-1){1'b1}}};
  localparam logic [OL-1:0] MIN_OL = {1'b1, {(OL-1){1'b0}}};
`ifdef IBF_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  function automatic logic [OL-1:0] sat_or_wrap(input logic [IL-1:0] r);
    logic fits;
    fits = (r[IL-1:OL-1] == '0) || (r[IL-1:OL-1] == '1);
    return (fits || !SAT_EN) ? r[OL-1:0] : (r[IL-1] ? MIN_OL : MAX_OL);
  endfunction
endpackage

// File: rtl/ibf_pipe_if.sv
// ibf_pipe_if: stream, output and error-reporting signals of the inverse butterfly.
interface ibf_pipe_if;
  import ibf_pkg::*;
  logic [IL-1:0] iDATA_add;
  logic [IL-1:0] iDATA_sub;
  logic iVALID;
  logic iREADY;
  logic [OL-1:0] oDATA1;
  logic [OL-1:0] oDATA2;
  logic oVALID;
  logic oREADY;
  logic oPAR_ERR;
  logic oRNG_ERR;
  logic [CW-1:0] oERR_CNT;
  logic iCLR_ERR;
  modport master (
    output iDATA_add, iDATA_sub, iVALID, oREADY, iCLR_ERR,
    input  iREADY, oDATA1, oDATA2, oVALID, oPAR_ERR, oRNG_ERR, oERR_CNT
  );
  modport slave (
    input  iDATA_add, iDATA_sub, iVALID, oREADY, iCLR_ERR,
    output iREADY, oDATA1, oDATA2, oVALID, oPAR_ERR, oRNG_ERR, oERR_CNT
  );
endinterface

// File: rtl/ibf_reduce.sv
// ibf_reduce: halve an exact sum/difference, flag out-of-range results and reduce to OL bits.
module ibf_reduce
  import ibf_pkg::*;
(
  input  logic [IL:0]   v,
  output logic [OL-1:0] q,
  output logic          rng,
  output logic          odd
);
  logic [IL-1:0] r;
  // dropping the lsb of the two's complement value is an arithmetic floor shift
  assign r   = v[IL:1];
  assign rng = (r[IL-1:OL-1] != '0) && (r[IL-1:OL-1] != '1);
  assign q   = sat_or_wrap(r);
  assign odd = v[0];
endmodule

// File: rtl/ibf_pipe.sv
// ibf_pipe: two-stage inverse radix-2 butterfly with parity/range checks; IBF_SAT_EN clamps instead of wrapping.
module ibf_pipe
  import ibf_pkg::*;
(
  input logic      iCLK,
  input logic      iRST,
  ibf_pipe_if.slave bus
);
  logic          s1_valid;
  logic [IL:0]   s1_sum;
  logic [IL:0]   s1_dif;
  logic          s2_par;
  logic          s2_rng;
  logic [OL-1:0] q1;
  logic [OL-1:0] q2;
  logic          rng1;
  logic          rng2;
  logic          odd1;
  logic          odd2;
  logic          s1_adv;
  logic          s2_adv;
  logic          xfer;
  assign s2_adv     = !bus.oVALID || bus.oREADY;
  assign s1_adv     = !s1_valid || s2_adv;
  assign bus.iREADY = s1_adv;
  assign xfer       = bus.oVALID && bus.oREADY;
  ibf_reduce u_red1 (.v(s1_sum), .q(q1), .rng(rng1), .odd(odd1));
  ibf_reduce u_red2 (.v(s1_dif), .q(q2), .rng(rng2), .odd(odd2));
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_dif   <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.iVALID;
      if (bus.iVALID) begin
        s1_sum <= {bus.iDATA_add[IL-1], bus.iDATA_add} + {bus.iDATA_sub[IL-1], bus.iDATA_sub};
        s1_dif <= {bus.iDATA_add[IL-1], bus.iDATA_add} - {bus.iDATA_sub[IL-1], bus.iDATA_sub};
      end
    end
  end
  // sum and difference always share their lsb, which is the parity s[0]^d[0]
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bus.oVALID <= 1'b0;
      bus.oDATA1 <= '0;
      bus.oDATA2 <= '0;
      s2_par     <= 1'b0;
      s2_rng     <= 1'b0;
    end else if (s2_adv) begin
      bus.oVALID <= s1_valid;
      if (s1_valid) begin
        bus.oDATA1 <= q1;
        bus.oDATA2 <= q2;
        s2_par     <= odd1 | odd2;
        s2_rng     <= rng1 | rng2;
      end
    end
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bus.oPAR_ERR <= 1'b0;
      bus.oRNG_ERR <= 1'b0;
      bus.oERR_CNT <= '0;
    end else begin
      bus.oPAR_ERR <= xfer && s2_par;
      bus.oRNG_ERR <= xfer && s2_rng;
      if (bus.iCLR_ERR)
        bus.oERR_CNT <= '0;
      else if (xfer && (s2_par || s2_rng) && bus.oERR_CNT != '1)
        bus.oERR_CNT <= bus.oERR_CNT + 1'b1;
    end
  end
endmodule

// File: tb/tb_ibf_pipe.sv
// tb_ibf_pipe: directed checks of ibf_pipe (round trip, backpressure, errors, counter, reset).
module tb_ibf_pipe;
  import ibf_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
`ifdef IBF_SAT_EN
  localparam int RNG_A = 32767;
`else
  localparam int RNG_A = -1;
`endif
  ibf_pipe_if bus ();
  ibf_pipe dut (.iCLK(clk), .iRST(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int s, input int d);
    bus.iDATA_add = IL'(s);
    bus.iDATA_sub = IL'(d);
    bus.iVALID    = 1'b1;
  endtask
  task automatic beat(input int s, input int d);
    drive(s, d);
    tick();
    bus.iVALID = 1'b0;
    tick();
  endtask
  function automatic int a1();
    return int'($signed(bus.oDATA1));
  endfunction
  function automatic int a2();
    return int'($signed(bus.oDATA2));
  endfunction
  int bs[4] = '{10, -20, 0, -1};
  int bd[4] = '{4, 6, 0, -1};
  int ea[4] = '{7, -7, 0, -1};
  int eb[4] = '{3, -13, 0, 0};
  initial begin
    int n_in;
    int n_out;
    int seen;
    bus.iDATA_add = '0;
    bus.iDATA_sub = '0;
    bus.iVALID    = 1'b0;
    bus.oREADY    = 1'b1;
    bus.iCLR_ERR  = 1'b0;
    repeat (2) tick();
    check("rst_ovalid", int'(bus.oVALID), 0);
    check("rst_d1", a1(), 0);
    check("rst_d2", a2(), 0);
    check("rst_par", int'(bus.oPAR_ERR), 0);
    check("rst_rng", int'(bus.oRNG_ERR), 0);
    check("rst_cnt", int'(bus.oERR_CNT), 0);
    rst = 1'b0;
    #1;
    check("rst_iready", int'(bus.iREADY), 1);
    tick();
    drive(70, 130);
    tick();
    bus.iVALID = 1'b0;
    check("rt_lat1", int'(bus.oVALID), 0);
    tick();
    check("rt_valid", int'(bus.oVALID), 1);
    check("rt_a", a1(), 100);
    check("rt_b", a2(), -30);
    tick();
    check("rt_drain", int'(bus.oVALID), 0);
    check("rt_par", int'(bus.oPAR_ERR), 0);
    check("rt_rng", int'(bus.oRNG_ERR), 0);
    check("rt_cnt", int'(bus.oERR_CNT), 0);
    beat(3, 0);
    check("par_a", a1(), 1);
    check("par_b", a2(), 1);
    check("par_pre", int'(bus.oPAR_ERR), 0);
    tick();
    check("par_pulse", int'(bus.oPAR_ERR), 1);
    check("par_norng", int'(bus.oRNG_ERR), 0);
    check("par_cnt", int'(bus.oERR_CNT), 1);
    tick();
    check("par_once", int'(bus.oPAR_ERR), 0);
    beat(65535, 65535);
    check("rng_a", a1(), RNG_A);
    check("rng_b", a2(), 0);
    tick();
    check("rng_pulse", int'(bus.oRNG_ERR), 1);
    check("rng_nopar", int'(bus.oPAR_ERR), 0);
    check("rng_cnt", int'(bus.oERR_CNT), 2);
    tick();
    check("rng_once", int'(bus.oRNG_ERR), 0);
    n_in  = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.oREADY = (cyc >= 4);
      #1;
      if (cyc == 2) begin
        check("bp_iready", int'(bus.iREADY), 0);
        check("bp_accepted", n_in, 2);
      end
      if (cyc == 3) begin
        check("bp_hold_v", int'(bus.oVALID), 1);
        check("bp_hold_a", a1(), ea[0]);
        check("bp_hold_b", a2(), eb[0]);
      end
      if (bus.oVALID && bus.oREADY) begin
        if (n_out < 4) begin
          check($sformatf("bp_a%0d", n_out), a1(), ea[n_out]);
          check($sformatf("bp_b%0d", n_out), a2(), eb[n_out]);
        end
        n_out++;
      end
      if (n_in < 4 && bus.iREADY) begin
        drive(bs[n_in], bd[n_in]);
        n_in++;
      end else
        bus.iVALID = 1'b0;
      tick();
    end
    check("bp_count", n_out, 4);
    check("bp_cnt", int'(bus.oERR_CNT), 2);
    bus.oREADY = 1'b0;
    drive(10, 4);
    tick();
    drive(10, 4);
    tick();
    bus.iVALID = 1'b0;
    check("rs_full", int'(bus.oVALID), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rs_ovalid", int'(bus.oVALID), 0);
    check("rs_cnt", int'(bus.oERR_CNT), 0);
    tick();
    rst = 1'b0;
    #1;
    check("rs_iready", int'(bus.iREADY), 1);
    bus.oREADY = 1'b1;
    seen = 0;
    repeat (5) begin
      tick();
      seen += int'(bus.oVALID);
    end
    check("rs_noout", seen, 0);
    drive(3, 0);
    repeat (300) tick();
    bus.iVALID = 1'b0;
    repeat (3) tick();
    check("sat_cnt", int'(bus.oERR_CNT), 255);
    beat(3, 0);
    check("clr_valid", int'(bus.oVALID), 1);
    bus.iCLR_ERR = 1'b1;
    tick();
    bus.iCLR_ERR = 1'b0;
    check("clr_cnt", int'(bus.oERR_CNT), 0);
    check("clr_par", int'(bus.oPAR_ERR), 1);
    tick();
    check("clr_hold", int'(bus.oERR_CNT), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
